// File: rtl/skid_pipe_reg.sv
// -----------------------------------------------------------------------------
// skid_pipe_reg
//
// Two-entry pipeline stage boundary with a valid/ready handshake, synchronous
// flush and a one-entry skid buffer. It sits in front of the enable-DFF
// register banks between pipeline stages (IF/ID, ID/EX, ...).
//
// The stage sustains one beat per cycle while out_ready stays high. in_ready
// is decoded only from the state register, so a downstream stall never forms
// a combinational path from out_ready back to in_ready. The second (skid)
// entry catches the beat that upstream launched in the same cycle that
// downstream stalled.
//
// Storage:
//   main  - the head entry, always the beat presented on out_data
//   skid  - the second-oldest entry, valid only in FULL
//
// Ports:
//   clk        in   1      clock, all state updates on posedge
//   reset_n    in   1      asynchronous active-low reset
//   flush      in   1      synchronous squash of all held entries
//   in_valid   in   1      upstream presents in_data this cycle
//   in_data    in   WIDTH  upstream payload
//   in_ready   out  1      stage can accept a beat (registered decode)
//   out_valid  out  1      out_data holds a valid beat (registered decode)
//   out_data   out  WIDTH  payload to downstream (registered)
//   out_ready  in   1      downstream accepts the out_data beat this cycle
//   count      out  2      number of held entries, 0..2 (registered decode)
// -----------------------------------------------------------------------------
module skid_pipe_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  // The encoding equals the occupancy, so count is a plain copy of the
  // state register and needs no decode logic.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic in_fire;
  logic out_fire;

  // ---------------------------------------------------------------------------
  // Output decode: every output is a function of registers only.
  // ---------------------------------------------------------------------------
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign count     = state;
  assign out_data  = main_q;

  assign in_fire  = in_valid  & in_ready;
  assign out_fire = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Squash wins over any handshake in the same cycle. The data registers
      // are left alone: out_data simply holds while out_valid drops.
      state_d = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end

        ONE: begin
          if (in_fire && out_fire) begin
            // Head leaves and the new beat takes its place: full throughput.
            main_d = in_data;
          end else if (in_fire) begin
            // Downstream stalled while upstream sent: park the beat in skid.
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end

        FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end

        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= EMPTY;
      // NOTE: the payload registers are reset as well even though out_valid
      // already qualifies them; this keeps out_data free of X after reset.
      main_q <= '0;
      skid_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state  <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: tb/tb_skid_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_skid_pipe_reg
//
// Self-checking bench for skid_pipe_reg (WIDTH=8). A queue models the stage:
// a beat is pushed when the bench sees it accepted and popped when the
// downstream side takes it. The expected occupancy, in_ready, out_valid and
// head data all derive from that queue. Outputs are sampled on the falling
// edge; inputs change 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_skid_pipe_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   count;

  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;
  logic [W-1:0] sb[$];
  bit           last_acc;
  int unsigned  n_out = 0;

  always #5 clk = ~clk;

  skid_pipe_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit r,
                       input bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  // One clock: check outputs against the model, then advance the model by
  // the handshakes that occur at the coming edge.
  task automatic tick();
    bit in_f;
    bit out_f;
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    check("in_ready",  64'(in_ready),  64'(sb.size() != 2));
    check("count",     64'(count),     64'(sb.size()));
    check("out_data_known", 64'($isunknown(out_data)), 64'(0));
    if (sb.size() != 0) check("out_data", 64'(out_data), 64'(sb[0]));
    in_f  = in_valid && (sb.size() != 2);
    out_f = out_ready && (sb.size() != 0);
    @(posedge clk);
    #1;
    last_acc = 1'b0;
    if (flush) begin
      sb.delete();
    end else begin
      if (out_f) begin
        void'(sb.pop_front());
        n_out++;
      end
      if (in_f) begin
        sb.push_back(in_data);
        last_acc = 1'b1;
      end
    end
  endtask

  // Present a beat and keep it until accepted, within a cycle budget.
  task automatic send(input logic [W-1:0] d, input bit r);
    int n;
    n = 0;
    drive(1'b1, d, r, 1'b0);
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    check("send_timeout", 64'(last_acc), 64'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    drive(1'b0, '0, 1'b1, 1'b0);
    while (sb.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
    tick();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pend;
    bit           pend_v;
    int unsigned  n_before;

    // ---- 1: asynchronous reset, checked before any clock edge ------------
    drive(1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_count",     64'(count),     64'(0));
    check("rst_out_data",  64'(out_data),  64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- 2: streaming at full rate -----------------------------------------
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      tick();
    end
    drain();

    // ---- 3: back-pressure and skid ---------------------------------------
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    // in_ready must not follow out_ready combinationally while FULL.
    #2;
    check("bp_in_ready_stall", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", 64'(in_ready), 64'(0));
    send(8'hC3, 1'b1);
    drain();

    // ---- 4: simultaneous accept and drain in ONE -------------------------
    send(8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b1, 1'b0);
    tick();
    check("simul_acc", 64'(last_acc), 64'(1));
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    drain();

    // ---- 5: flush while FULL ----------------------------------------------
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    n_before = n_out;
    drive(1'b1, 8'h55, 1'b1, 1'b1);
    tick();
    check("flush_no_delivery", 64'(n_out), 64'(n_before));
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    send(8'h66, 1'b1);
    drain();

    // ---- reset asserted mid-transfer --------------------------------------
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst2_out_valid", 64'(out_valid), 64'(0));
    check("rst2_in_ready",  64'(in_ready),  64'(1));
    check("rst2_count",     64'(count),     64'(0));
    check("rst2_out_data",  64'(out_data),  64'(0));
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h99, 1'b1);
    drain();

    // ---- 6: randomised valid/ready with rare flush -------------------------
    pend_v = 1'b0;
    pend   = '0;
    for (int c = 0; c < 1000; c++) begin
      if (!pend_v && ($urandom_range(0, 3) != 0)) begin
        pend_v = 1'b1;
        pend   = W'($urandom_range(0, 255));
      end
      drive(pend_v, pend, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 63) == 0));
      tick();
      if (last_acc) pend_v = 1'b0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
